// File: rtl/dmem_mmio_bridge_if.sv
// ---------------------------------------------------------------------------
// dmem_mmio_bridge_if
//
// MMIO device bus between the data-memory bridge (master) and a bank of
// N_PORTS equally spaced device channels (slave).
//
//   io_sel    master->slave  one-hot channel select, held for the whole access
//   io_read   master->slave  read strobe
//   io_write  master->slave  write strobe
//   io_off    master->slave  word offset inside the selected channel
//   io_wdata  master->slave  store data, stable while the strobe is high
//   io_be     master->slave  store byte enables, stable while the strobe is high
//   io_rdata  slave->master  read data, channel k at bits [32k+31:32k]
//   io_ack    slave->master  per-channel acknowledge
// ---------------------------------------------------------------------------
interface dmem_mmio_bridge_if #(
  parameter int N_PORTS     = 4,
  parameter int STRIDE_LOG2 = 2
);
  logic [N_PORTS-1:0]     io_sel;
  logic                   io_read;
  logic                   io_write;
  logic [STRIDE_LOG2-1:0] io_off;
  logic [31:0]            io_wdata;
  logic [3:0]             io_be;
  logic [32*N_PORTS-1:0]  io_rdata;
  logic [N_PORTS-1:0]     io_ack;

  modport master (
    output io_sel, io_read, io_write, io_off, io_wdata, io_be,
    input  io_rdata, io_ack
  );

  modport slave (
    input  io_sel, io_read, io_write, io_off, io_wdata, io_be,
    output io_rdata, io_ack
  );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// ---------------------------------------------------------------------------
// dmem_mmio_bridge
//
// Splits CPU data accesses between the cached DDR path and a window of
// N_PORTS memory-mapped I/O channels, each 2**STRIDE_LOG2 words wide,
// starting at word address MMIO_BASE.
//
// Cached accesses pass straight through to the cache manage unit with no
// register in the path. MMIO accesses run IDLE -> REQ -> DONE: the request is
// latched, the channel strobe is held until that channel acks or TIMEOUT+1
// REQ cycles elapse, and the CPU is released in DONE with the captured data
// (32'hDEAD_BEEF on timeout).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   dmem_read_in     CPU load request (held while mem_stall)
//   dmem_write_in    CPU store request (held while mem_stall), wins over read
//   dmem_addr        CPU word address
//   data_from_reg    store data
//   dc_byte_w_en     store byte enables
//   dmem_data_out    load data to the CPU
//   mem_stall        CPU stall
//   dc_read_out      read request to the cache manage unit
//   dc_write_out     write request to the cache manage unit
//   dc_data_in       load data from the cache
//   dc_stall_in      stall from the cache
//   io               MMIO device bus (master side)
//   io_timeout       one-cycle pulse in the DONE cycle of a timed-out access
//   io_err_addr      word address of the most recent timed-out access
// ---------------------------------------------------------------------------
module dmem_mmio_bridge #(
  parameter int          N_PORTS     = 4,
  parameter logic [29:0] MMIO_BASE   = 30'h1000,
  parameter int          STRIDE_LOG2 = 2,
  parameter int          TIMEOUT     = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dmem_read_in,
  input  logic                dmem_write_in,
  input  logic [29:0]         dmem_addr,
  input  logic [31:0]         data_from_reg,
  input  logic [3:0]          dc_byte_w_en,
  output logic [31:0]         dmem_data_out,
  output logic                mem_stall,
  output logic                dc_read_out,
  output logic                dc_write_out,
  input  logic [31:0]         dc_data_in,
  input  logic                dc_stall_in,
  dmem_mmio_bridge_if.master  io,
  output logic                io_timeout,
  output logic [29:0]         io_err_addr
);

  localparam int          K_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int          CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [29:0] WINDOW = 30'(N_PORTS) << STRIDE_LOG2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state_reg;
  logic [K_W-1:0]     k_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [29:0]        addr_reg;
  logic [31:0]        rdata_reg;

  // Subtracting the base first makes addresses below the window wrap to a
  // large value, so a single unsigned compare covers both window edges.
  logic [29:0]        addr_diff;
  logic               hit;
  logic               req_active;
  logic               mmio_start;
  logic [K_W-1:0]     k_idx;
  logic [N_PORTS-1:0] sel_dec;
  logic [31:0]        rdata_arr [N_PORTS];
  logic               ack_sel;

  assign addr_diff  = dmem_addr - MMIO_BASE;
  assign hit        = addr_diff < WINDOW;
  assign req_active = dmem_read_in | dmem_write_in;
  assign mmio_start = (state_reg == IDLE) && req_active && hit;
  assign k_idx      = K_W'(addr_diff >> STRIDE_LOG2);
  assign ack_sel    = io.io_ack[k_reg];

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign sel_dec[gi]   = (k_idx == K_W'(gi));
    assign rdata_arr[gi] = io.io_rdata[32*gi +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      rdata_reg   <= '0;
      io.io_sel   <= '0;
      io.io_read  <= 1'b0;
      io.io_write <= 1'b0;
      io.io_off   <= '0;
      io.io_wdata <= '0;
      io.io_be    <= '0;
      io_timeout  <= 1'b0;
      io_err_addr <= '0;
    end else begin
      io_timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mmio_start) begin
            state_reg   <= REQ;
            k_reg       <= k_idx;
            cnt_reg     <= '0;
            addr_reg    <= dmem_addr;
            io.io_sel   <= sel_dec;
            // A simultaneous read and write is treated as a write.
            io.io_write <= dmem_write_in;
            io.io_read  <= ~dmem_write_in;
            io.io_off   <= addr_diff[STRIDE_LOG2-1:0];
            io.io_wdata <= data_from_reg;
            io.io_be    <= dc_byte_w_en;
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + 1'b1;
          // Ack is tested before the timeout so a last-cycle ack still wins.
          if (ack_sel) begin
            rdata_reg   <= io.io_write ? 32'h0 : rdata_arr[k_reg];
            state_reg   <= DONE;
            io.io_sel   <= '0;
            io.io_read  <= 1'b0;
            io.io_write <= 1'b0;
          end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
            rdata_reg   <= 32'hDEAD_BEEF;
            io_err_addr <= addr_reg;
            io_timeout  <= 1'b1;
            state_reg   <= DONE;
            io.io_sel   <= '0;
            io.io_read  <= 1'b0;
            io.io_write <= 1'b0;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // CPU/cache side. Only IDLE without a window hit touches the cache.
  always_comb begin
    dc_read_out   = 1'b0;
    dc_write_out  = 1'b0;
    mem_stall     = 1'b1;
    dmem_data_out = dc_data_in;
    case (state_reg)
      IDLE: begin
        if (!(req_active && hit)) begin
          dc_read_out  = dmem_read_in;
          dc_write_out = dmem_write_in;
          mem_stall    = dc_stall_in;
        end
      end
      REQ:  mem_stall = 1'b1;
      DONE: begin
        mem_stall     = 1'b0;
        dmem_data_out = rdata_reg;
      end
      default: mem_stall = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
module tb_dmem_mmio_bridge;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_read_in, dmem_write_in;
  logic [29:0] dmem_addr;
  logic [31:0] data_from_reg;
  logic [3:0]  dc_byte_w_en;
  logic [31:0] dmem_data_out;
  logic        mem_stall, dc_read_out, dc_write_out;
  logic [31:0] dc_data_in;
  logic        dc_stall_in;
  logic        io_timeout;
  logic [29:0] io_err_addr;

  dmem_mmio_bridge_if #(.N_PORTS(4), .STRIDE_LOG2(2)) bus ();

  dmem_mmio_bridge #(
    .N_PORTS(4), .MMIO_BASE(30'h1000), .STRIDE_LOG2(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .dmem_read_in(dmem_read_in), .dmem_write_in(dmem_write_in),
    .dmem_addr(dmem_addr), .data_from_reg(data_from_reg),
    .dc_byte_w_en(dc_byte_w_en), .dmem_data_out(dmem_data_out),
    .mem_stall(mem_stall), .dc_read_out(dc_read_out),
    .dc_write_out(dc_write_out), .dc_data_in(dc_data_in),
    .dc_stall_in(dc_stall_in), .io(bus),
    .io_timeout(io_timeout), .io_err_addr(io_err_addr)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_data;

  // Observations from the last MMIO access.
  int          r_stall, r_req, r_to;
  logic        r_done, r_rd, r_wr, r_dc, r_stable;
  logic [31:0] r_data, r_w;
  logic [3:0]  r_sel, r_b;
  logic [1:0]  r_off;

  // Drives one MMIO access and plays the device: acks on channel ack_ch from
  // REQ cycle ack_at onward (ack_at = 0 never acks). Samples 2 ns after edges.
  task automatic run_mmio(input logic rd, input logic wr, input logic [29:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int ack_ch, input int ack_at);
    r_stall = 0; r_req = 0; r_to = 0; r_done = 1'b0; r_rd = 1'b0; r_wr = 1'b0;
    r_dc = 1'b0; r_stable = 1'b1; r_data = '0; r_w = '0; r_sel = '0; r_b = '0; r_off = '0;
    @(posedge clk); #2;
    dmem_read_in = rd; dmem_write_in = wr; dmem_addr = addr;
    data_from_reg = wdata; dc_byte_w_en = be; bus.io_ack = '0;
    #1;
    for (int c = 0; c < 60 && !r_done; c++) begin
      if (io_timeout) r_to++;
      if (dc_read_out || dc_write_out) r_dc = 1'b1;
      if (bus.io_sel != 4'b0) begin
        r_req++;
        r_sel |= bus.io_sel; r_rd |= bus.io_read; r_wr |= bus.io_write; r_off = bus.io_off;
        if (r_req == 1) begin
          r_w = bus.io_wdata; r_b = bus.io_be;
        end else if (bus.io_wdata !== r_w || bus.io_be !== r_b) begin
          r_stable = 1'b0;
        end
        bus.io_ack = (ack_at > 0 && r_req >= ack_at) ? 4'(1 << ack_ch) : 4'b0;
      end else begin
        bus.io_ack = '0;
      end
      if (mem_stall) r_stall++;
      else if (c > 0) begin
        r_done = 1'b1;
        r_data = dmem_data_out;
      end
      if (!r_done) begin
        @(posedge clk); #2;
      end
    end
    @(posedge clk); #2;
    if (io_timeout) r_to++;
    dmem_read_in = 1'b0; dmem_write_in = 1'b0; bus.io_ack = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    dc_stall_in = 1'b1; dc_data_in = 32'h5A5A_1234; #1;
    total_cnt++; if (bus.io_sel !== 4'b0) $display("FAIL rst_io_sel: got %b expected 0000", bus.io_sel); else pass_cnt++;
    total_cnt++; if (bus.io_read !== 1'b0 || bus.io_write !== 1'b0) $display("FAIL rst_strobes: got rd=%b wr=%b expected 0 0", bus.io_read, bus.io_write); else pass_cnt++;
    total_cnt++; if (bus.io_off !== 2'b0 || bus.io_wdata !== 32'h0 || bus.io_be !== 4'h0) $display("FAIL rst_io_regs: got off=%h wdata=%h be=%h expected 0", bus.io_off, bus.io_wdata, bus.io_be); else pass_cnt++;
    total_cnt++; if (io_timeout !== 1'b0 || io_err_addr !== 30'h0) $display("FAIL rst_err: got to=%b addr=%h expected 0 0", io_timeout, io_err_addr); else pass_cnt++;
    total_cnt++; if (mem_stall !== 1'b1 || dmem_data_out !== 32'h5A5A_1234) $display("FAIL rst_passthru: got stall=%b data=%h expected 1 5a5a1234", mem_stall, dmem_data_out); else pass_cnt++;
    dc_stall_in = 1'b0; dc_data_in = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_cached_read();
    logic exp_stall;
    @(posedge clk); #2;
    dmem_read_in = 1'b1; dmem_addr = 30'h0000_0100; dc_data_in = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      exp_stall = (c < 3);
      dc_stall_in = exp_stall; #1;
      total_cnt++; if (dc_read_out !== 1'b1 || dc_write_out !== 1'b0) $display("FAIL cached_dc_req c%0d: got rd=%b wr=%b expected 1 0", c, dc_read_out, dc_write_out); else pass_cnt++;
      total_cnt++; if (mem_stall !== exp_stall) $display("FAIL cached_stall c%0d: got %b expected %b", c, mem_stall, exp_stall); else pass_cnt++;
      total_cnt++; if (bus.io_sel !== 4'b0) $display("FAIL cached_io_sel c%0d: got %b expected 0000", c, bus.io_sel); else pass_cnt++;
      total_cnt++; if (dmem_data_out !== 32'h1234_5678) $display("FAIL cached_data c%0d: got %h expected 12345678", c, dmem_data_out); else pass_cnt++;
      @(posedge clk); #2;
    end
    dc_data_in = 32'h8765_4321; #1;
    total_cnt++; if (dmem_data_out !== 32'h8765_4321) $display("FAIL cached_comb_data: got %h expected 87654321", dmem_data_out); else pass_cnt++;
    dmem_read_in = 1'b0; #1;
    total_cnt++; if (dc_read_out !== 1'b0) $display("FAIL cached_release: got %b expected 0", dc_read_out); else pass_cnt++;
  endtask

  task automatic test_mmio_read_imm();
    exp_q.push_back(32'hA5A5_0001);
    run_mmio(1'b1, 1'b0, 30'h1004, 32'h0, 4'h0, 1, 1);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_done !== 1'b1) $display("FAIL imm_done: got %b expected 1", r_done); else pass_cnt++;
    total_cnt++; if (r_data !== exp_data) $display("FAIL imm_data: got %h expected %h", r_data, exp_data); else pass_cnt++;
    total_cnt++; if (r_stall !== 2 || r_req !== 1) $display("FAIL imm_timing: got stall=%0d req=%0d expected 2 1", r_stall, r_req); else pass_cnt++;
    total_cnt++; if (r_sel !== 4'b0010 || r_rd !== 1'b1 || r_wr !== 1'b0 || r_off !== 2'd0) $display("FAIL imm_bus: got sel=%b rd=%b wr=%b off=%0d expected 0010 1 0 0", r_sel, r_rd, r_wr, r_off); else pass_cnt++;
    total_cnt++; if (r_dc !== 1'b0 || r_to !== 0) $display("FAIL imm_side: got dc=%b to=%0d expected 0 0", r_dc, r_to); else pass_cnt++;
  endtask

  task automatic test_mmio_write_delayed();
    exp_q.push_back(32'h0);
    run_mmio(1'b0, 1'b1, 30'h100E, 32'hCAFE_F00D, 4'b0011, 3, 5);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_done !== 1'b1 || r_data !== exp_data) $display("FAIL wr_done: got done=%b data=%h expected 1 %h", r_done, r_data, exp_data); else pass_cnt++;
    total_cnt++; if (r_stall !== 6 || r_req !== 5) $display("FAIL wr_timing: got stall=%0d req=%0d expected 6 5", r_stall, r_req); else pass_cnt++;
    total_cnt++; if (r_sel !== 4'b1000 || r_wr !== 1'b1 || r_rd !== 1'b0 || r_off !== 2'd2) $display("FAIL wr_bus: got sel=%b rd=%b wr=%b off=%0d expected 1000 0 1 2", r_sel, r_rd, r_wr, r_off); else pass_cnt++;
    total_cnt++; if (r_w !== 32'hCAFE_F00D || r_b !== 4'b0011 || r_stable !== 1'b1) $display("FAIL wr_payload: got wdata=%h be=%b stable=%b expected cafef00d 0011 1", r_w, r_b, r_stable); else pass_cnt++;
    total_cnt++; if (r_dc !== 1'b0) $display("FAIL wr_dc: got %b expected 0", r_dc); else pass_cnt++;
  endtask

  task automatic test_timeout();
    exp_q.push_back(32'hDEAD_BEEF);
    run_mmio(1'b1, 1'b0, 30'h1008, 32'h0, 4'h0, 0, 1);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_done !== 1'b1 || r_data !== exp_data) $display("FAIL to_data: got done=%b data=%h expected 1 %h", r_done, r_data, exp_data); else pass_cnt++;
    total_cnt++; if (r_req !== TIMEOUT + 1 || r_stall !== TIMEOUT + 2) $display("FAIL to_timing: got req=%0d stall=%0d expected %0d %0d", r_req, r_stall, TIMEOUT + 1, TIMEOUT + 2); else pass_cnt++;
    total_cnt++; if (r_to !== 1) $display("FAIL to_pulse: got %0d pulses expected 1", r_to); else pass_cnt++;
    total_cnt++; if (r_sel !== 4'b0100) $display("FAIL to_sel: got %b expected 0100", r_sel); else pass_cnt++;
    total_cnt++; if (io_err_addr !== 30'h1008) $display("FAIL to_err_addr: got %h expected 1008", io_err_addr); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic [29:0] miss_addr [2];
    miss_addr[0] = 30'h0FFF; miss_addr[1] = 30'h1010;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      dmem_read_in = 1'b1; dmem_addr = miss_addr[i]; dc_stall_in = 1'b0; #1;
      total_cnt++; if (dc_read_out !== 1'b1 || mem_stall !== 1'b0) $display("FAIL bound_miss_%h: got dc_rd=%b stall=%b expected 1 0", miss_addr[i], dc_read_out, mem_stall); else pass_cnt++;
      @(posedge clk); #2;
      total_cnt++; if (bus.io_sel !== 4'b0) $display("FAIL bound_sel_%h: got %b expected 0000", miss_addr[i], bus.io_sel); else pass_cnt++;
      dmem_read_in = 1'b0;
    end
    exp_q.push_back(32'hA5A5_0003);
    run_mmio(1'b1, 1'b0, 30'h100F, 32'h0, 4'h0, 3, 1);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_sel !== 4'b1000 || r_off !== 2'd3 || r_data !== exp_data) $display("FAIL bound_top: got sel=%b off=%0d data=%h expected 1000 3 %h", r_sel, r_off, r_data, exp_data); else pass_cnt++;
    exp_q.push_back(32'h0);
    run_mmio(1'b1, 1'b1, 30'h1000, 32'h1111_2222, 4'hF, 0, 1);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_wr !== 1'b1 || r_rd !== 1'b0 || r_sel !== 4'b0001) $display("FAIL rw_priority: got wr=%b rd=%b sel=%b expected 1 0 0001", r_wr, r_rd, r_sel); else pass_cnt++;
    total_cnt++; if (r_data !== exp_data || r_dc !== 1'b0) $display("FAIL rw_data: got data=%h dc=%b expected %h 0", r_data, r_dc, exp_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #2;
    dmem_read_in = 1'b1; dmem_addr = 30'h1000; bus.io_ack = '0;
    @(posedge clk); #2;
    total_cnt++; if (bus.io_sel !== 4'b0001 || bus.io_read !== 1'b1) $display("FAIL midrst_req1: got sel=%b rd=%b expected 0001 1", bus.io_sel, bus.io_read); else pass_cnt++;
    @(posedge clk); #2;
    rst = 1'b1; dmem_read_in = 1'b0; #1;
    total_cnt++; if (bus.io_sel !== 4'b0 || bus.io_read !== 1'b0 || mem_stall !== 1'b0) $display("FAIL midrst_clear: got sel=%b rd=%b stall=%b expected 0000 0 0", bus.io_sel, bus.io_read, mem_stall); else pass_cnt++;
    total_cnt++; if (io_err_addr !== 30'h0) $display("FAIL midrst_err_addr: got %h expected 0", io_err_addr); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    exp_q.push_back(32'hA5A5_0000);
    run_mmio(1'b1, 1'b0, 30'h1000, 32'h0, 4'h0, 0, 1);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_done !== 1'b1 || r_data !== exp_data || r_stall !== 2 || r_sel !== 4'b0001) $display("FAIL midrst_after: got done=%b data=%h stall=%0d sel=%b expected 1 %h 2 0001", r_done, r_data, r_stall, r_sel, exp_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'hA5A5_0000);
    exp_q.push_back(32'hA5A5_0002);
    run_mmio(1'b1, 1'b0, 30'h1000, 32'h0, 4'h0, 0, 2);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_data !== exp_data || r_stall !== 3) $display("FAIL b2b_first: got data=%h stall=%0d expected %h 3", r_data, r_stall, exp_data); else pass_cnt++;
    run_mmio(1'b1, 1'b0, 30'h100A, 32'h0, 4'h0, 2, 3);
    exp_data = exp_q.pop_front();
    total_cnt++; if (r_data !== exp_data || r_stall !== 4 || r_off !== 2'd2) $display("FAIL b2b_second: got data=%h stall=%0d off=%0d expected %h 4 2", r_data, r_stall, r_off, exp_data); else pass_cnt++;
  endtask

  initial begin
    dmem_read_in = 1'b0; dmem_write_in = 1'b0; dmem_addr = '0;
    data_from_reg = '0; dc_byte_w_en = '0; dc_data_in = '0; dc_stall_in = 1'b0;
    bus.io_ack = '0;
    bus.io_rdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    test_reset();
    test_cached_read();
    test_mmio_read_imm();
    test_mmio_write_delayed();
    test_timeout();
    test_boundaries();
    test_reset_mid_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", pass_cnt, total_cnt);
    $fatal(1);
  end
endmodule
